// File: rtl/avmm_cfg_arbiter.sv
// avmm_cfg_arbiter: round-robin arbiter that shares one Avalon-MM configuration
// master port among NREQ requester FSMs. It keeps at most one transaction in flight
// and returns read data only to the requester that issued the read.
// Optional feature macro: AVMM_ARB_TIMEOUT_EN enables the read-response watchdog
// (TIMEOUT_CYC); without it RDWAIT waits indefinitely and timeout_err is tied 0.
module avmm_cfg_arbiter #(
    parameter int NREQ        = 4,
    parameter int AW          = 17,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ*AW-1:0]        req_address,
    input  logic [NREQ*DW-1:0]        req_writedata,
    input  logic [NREQ*(DW/8)-1:0]    req_byteenable,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ-1:0]           req_read,
    output logic [NREQ-1:0]           req_waitrequest,
    output logic [DW-1:0]             req_readdata,
    output logic [NREQ-1:0]           req_readdatavalid,
    output logic [AW-1:0]             avmm_address,
    output logic [DW-1:0]             avmm_writedata,
    output logic [DW/8-1:0]           avmm_byteenable,
    output logic                      avmm_write,
    output logic                      avmm_read,
    input  logic                      avmm_waitrequest,
    input  logic [DW-1:0]             avmm_readdata,
    input  logic                      avmm_readdatavalid,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = DW / 8;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("avmm_cfg_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last;
    logic [GW-1:0]   arb_idx;
    logic            arb_found;
    logic            accept;
    logic            g_write, g_read;
    logic            rd_done;
    logic            rd_timeout;
    logic [NREQ-1:0] active;

    assign active  = req_write | req_read;
    assign g_write = req_write[grant_id];
    assign g_read  = req_read[grant_id];
    assign busy    = (state != IDLE);

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!arb_found && active[(int'(last) + k) % NREQ]) begin
                arb_found = 1'b1;
                arb_idx   = GW'((int'(last) + k) % NREQ);
            end
        end
    end

`ifdef AVMM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt;

    // Watchdog counter: zero outside RDWAIT, so it restarts on every RDWAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  to_cnt <= '0;
        else if (state != RDWAIT) to_cnt <= '0;
        else                      to_cnt <= to_cnt + 1'b1;
    end

    assign rd_timeout = (state == RDWAIT) && !avmm_readdatavalid && (to_cnt == CW'(TIMEOUT_CYC));

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             timeout_err <= 1'b0;
        else if (rd_timeout) timeout_err <= 1'b1;
    end
`else
    assign rd_timeout  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign rd_done = (state == RDWAIT) && avmm_readdatavalid;

    // Next-state and master/requester handshake decode.
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        avmm_address    = '0;
        avmm_writedata  = '0;
        avmm_byteenable = '0;
        avmm_write      = 1'b0;
        avmm_read       = 1'b0;
        req_waitrequest = '1;
        case (state)
            IDLE: begin
                if (arb_found) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!g_write && !g_read) begin
                    // Requester withdrew before acceptance: abandon without a master command.
                    state_nxt = IDLE;
                end else begin
                    avmm_address              = req_address[grant_id*AW +: AW];
                    avmm_writedata            = req_writedata[grant_id*DW +: DW];
                    avmm_byteenable           = req_byteenable[grant_id*BW +: BW];
                    avmm_write                = g_write;
                    avmm_read                 = g_read && !g_write;
                    req_waitrequest[grant_id] = avmm_waitrequest;
                    if (!avmm_waitrequest) begin
                        accept    = 1'b1;
                        state_nxt = g_write ? IDLE : RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (rd_done || rd_timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state always uses non-blocking (<=) so all flops sample pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant latch in IDLE; round-robin pointer moves only on master acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id <= '0;
            last     <= GW'(NREQ - 1);
        end else begin
            if (state == IDLE && arb_found) grant_id <= arb_idx;
            if (accept)                     last     <= grant_id;
        end
    end

    // Registered read return, strobed only to the requester that issued the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_readdata      <= '0;
            req_readdatavalid <= '0;
        end else begin
            req_readdatavalid <= '0;
            if (rd_done) begin
                req_readdata                <= avmm_readdata;
                req_readdatavalid[grant_id] <= 1'b1;
            end else if (rd_timeout) begin
                req_readdata                <= DW'(32'hDEAD_BEEF);
                req_readdatavalid[grant_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_cfg_arbiter.sv
// tb_avmm_cfg_arbiter: directed scoreboard bench for avmm_cfg_arbiter.
// Stimulus pushes expected master commands and read returns into queues; a monitor
// pops and compares whenever the DUT accepts a master command or strobes read data.
module tb_avmm_cfg_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 17;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int GW   = 2;
`ifdef AVMM_ARB_TIMEOUT_EN
    localparam int TOC = 16;
`else
    localparam int TOC = 256;
`endif

    logic                   clk;
    logic                   rst;
    logic [NREQ*AW-1:0]     req_address;
    logic [NREQ*DW-1:0]     req_writedata;
    logic [NREQ*BW-1:0]     req_byteenable;
    logic [NREQ-1:0]        req_write;
    logic [NREQ-1:0]        req_read;
    logic [NREQ-1:0]        req_waitrequest;
    logic [DW-1:0]          req_readdata;
    logic [NREQ-1:0]        req_readdatavalid;
    logic [AW-1:0]          avmm_address;
    logic [DW-1:0]          avmm_writedata;
    logic [BW-1:0]          avmm_byteenable;
    logic                   avmm_write;
    logic                   avmm_read;
    logic                   avmm_waitrequest;
    logic [DW-1:0]          avmm_readdata;
    logic                   avmm_readdatavalid;
    logic [GW-1:0]          grant_id;
    logic                   busy;
    logic                   timeout_err;

    avmm_cfg_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .rst(rst),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_byteenable(req_byteenable), .req_write(req_write), .req_read(req_read),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
        .avmm_byteenable(avmm_byteenable), .avmm_write(avmm_write), .avmm_read(avmm_read),
        .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit             wr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [BW-1:0]  be;
        int             g;
    } cmd_t;

    typedef struct {
        logic [NREQ-1:0] vec;
        logic [DW-1:0]   data;
    } rd_t;

    cmd_t exp_cmd[$];
    rd_t  exp_rd[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int            stall_cfg = 0;
    int            stall_cnt = 0;
    bit            rd_resp_en = 0;
    int            rd_lat = 5;
    logic [DW-1:0] rd_data = '0;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    logic          spur_valid = 1'b0;

    assign avmm_waitrequest   = (avmm_write || avmm_read) && (stall_cnt < stall_cfg);
    assign avmm_readdatavalid = rsp_valid | spur_valid;
    assign avmm_readdata      = rsp_valid ? rsp_data : (spur_valid ? 32'h0BAD_0BAD : '0);

    always @(posedge clk)
        stall_cnt <= ((avmm_write || avmm_read) && avmm_waitrequest) ? stall_cnt + 1 : 0;

    initial begin
        forever begin
            @(negedge clk);
            if (avmm_read && !avmm_waitrequest && rd_resp_en) begin
                repeat (rd_lat) @(posedge clk);
                #1 rsp_data = rd_data; rsp_valid = 1'b1;
                @(posedge clk);
                #1 rsp_valid = 1'b0; rsp_data = '0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int            wr_low_cnt [NREQ];
    int            wr_hi_cnt = 0;
    int            stab_err = 0;
    int            pulse_cnt = 0;
    bit            prev_acc = 0;
    bit            prev_wstall = 0;
    bit            rd_pending = 0;
    bit            saw_idle = 0;
    logic [AW-1:0] prev_addr = '0;

    initial begin
        cmd_t c;
        rd_t  r;
        bit   acc;
        for (int i = 0; i < NREQ; i++) wr_low_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_pending  = 0;
                prev_acc    = 0;
                prev_wstall = 0;
            end else begin
                for (int i = 0; i < NREQ; i++) if (!req_waitrequest[i]) wr_low_cnt[i]++;
                if (avmm_write) wr_hi_cnt++;
                if (avmm_write && prev_wstall && avmm_address !== prev_addr) stab_err++;
                prev_wstall = avmm_write && avmm_waitrequest;
                prev_addr   = avmm_address;
                acc = (avmm_write || avmm_read) && !avmm_waitrequest;
                if (acc) begin
                    if (exp_cmd.size() == 0) begin
                        check("unexpected_cmd_queue_size", 64'(exp_cmd.size()), 1);
                    end else begin
                        c = exp_cmd.pop_front();
                        check("cmd_is_write", avmm_write, c.wr);
                        check("cmd_is_read", avmm_read, !c.wr);
                        check("cmd_addr", avmm_address, c.addr);
                        if (c.wr) check("cmd_wdata", avmm_writedata, c.data);
                        check("cmd_be", avmm_byteenable, c.be);
                        check("cmd_grant_id", grant_id, c.g);
                    end
                    check("idle_cycle_before_cmd", prev_acc, 0);
                    check("cmd_while_read_pending", rd_pending, 0);
                    check("busy_dropped_between_grants", saw_idle, 1);
                    saw_idle = 0;
                    if (avmm_read) rd_pending = 1;
                end
                prev_acc = acc;
                if (!busy) saw_idle = 1;
                if (|req_readdatavalid) begin
                    pulse_cnt++;
                    if (exp_rd.size() == 0) begin
                        check("unexpected_rdv_queue_size", 64'(exp_rd.size()), 1);
                    end else begin
                        r = exp_rd.pop_front();
                        check("rdv_vector", req_readdatavalid, r.vec);
                        check("rdv_data", req_readdata, r.data);
                    end
                    rd_pending = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, input int g);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d; c.be = be; c.g = g;
        exp_cmd.push_back(c);
    endtask

    task automatic push_rd(input logic [NREQ-1:0] vec, input logic [DW-1:0] d);
        rd_t r;
        r.vec = vec; r.data = d;
        exp_rd.push_back(r);
    endtask

    // Requester i holds its command until it sees its waitrequest low.
    task automatic do_cmd(input int i, input bit wr, input bit rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
        bit ok = 0;
        @(posedge clk); #1;
        req_address[i*AW +: AW]    = a;
        req_writedata[i*DW +: DW]  = d;
        req_byteenable[i*BW +: BW] = be;
        req_write[i] = wr;
        req_read[i]  = rd;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (!req_waitrequest[i]) ok = 1;
        end
        @(posedge clk); #1;
        req_write[i] = 1'b0;
        req_read[i]  = 1'b0;
        check("request_accepted", ok, 1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 400 && (exp_cmd.size() + exp_rd.size()) != 0; c++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_cmd.size() + exp_rd.size()), 0);
    endtask

    task automatic t3_req(input int i);
        for (int k = 0; k < 2; k++)
            do_cmd(i, 1'b1, 1'b0, AW'(17'h100 + i*4 + k*'h40), 32'hA000_0000 | (i << 8) | k, 4'hF);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_avmm_write"}, avmm_write, 0);
        check({tag, "_avmm_read"}, avmm_read, 0);
        check({tag, "_avmm_address"}, avmm_address, 0);
        check({tag, "_avmm_writedata"}, avmm_writedata, 0);
        check({tag, "_avmm_byteenable"}, avmm_byteenable, 0);
        check({tag, "_req_waitrequest"}, req_waitrequest, 4'hF);
        check({tag, "_req_readdatavalid"}, req_readdatavalid, 0);
        check({tag, "_req_readdata"}, req_readdata, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lo, hi, st, pc;
        rst = 1'b1;
        req_address = '0; req_writedata = '0; req_byteenable = '0;
        req_write = '0; req_read = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 rst = 1'b0;

        // T3: all four write continuously; from reset the order is 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                push_cmd(1'b1, AW'(17'h100 + i*4 + k*'h40), 32'hA000_0000 | (i << 8) | k, 4'hF, i);
        fork
            t3_req(0);
            t3_req(1);
            t3_req(2);
            t3_req(3);
        join
        wait_drain();

        // T1: single write from requester 1.
        lo = wr_low_cnt[1];
        push_cmd(1'b1, 17'h00208, 32'h1234_5678, 4'hF, 1);
        do_cmd(1, 1'b1, 1'b0, 17'h00208, 32'h1234_5678, 4'hF);
        wait_drain();
        check("t1_waitrequest_low_once", wr_low_cnt[1] - lo, 1);
        check("t1_grant_id_held", grant_id, 1);

        // T2: slave stalls 3 cycles.
        stall_cfg = 3;
        lo = wr_low_cnt[0]; hi = wr_hi_cnt; st = stab_err;
        push_cmd(1'b1, 17'h00044, 32'h0BAD_F00D, 4'hC, 0);
        do_cmd(0, 1'b1, 1'b0, 17'h00044, 32'h0BAD_F00D, 4'hC);
        wait_drain();
        stall_cfg = 0;
        check("t2_write_high_cycles", wr_hi_cnt - hi, 4);
        check("t2_waitrequest_low_once", wr_low_cnt[0] - lo, 1);
        check("t2_address_stable", stab_err - st, 0);

        // Write and read both high: write wins, no read issued.
        pc = pulse_cnt;
        push_cmd(1'b1, 17'h0003C, 32'h55AA_55AA, 4'hF, 3);
        do_cmd(3, 1'b1, 1'b1, 17'h0003C, 32'h55AA_55AA, 4'hF);
        wait_drain();
        repeat (2) @(negedge clk);
        check("write_wins_not_busy", busy, 0);
        check("write_wins_no_rdv", pulse_cnt - pc, 0);

        // T4: read from requester 2; a write from requester 0 must wait for the data.
        rd_resp_en = 1; rd_lat = 5; rd_data = 32'hCAFE_0001;
        pc = pulse_cnt;
        push_cmd(1'b0, 17'h00010, '0, 4'hF, 2);
        push_rd(4'b0100, 32'hCAFE_0001);
        push_cmd(1'b1, 17'h00080, 32'h1111_2222, 4'h3, 0);
        fork
            do_cmd(2, 1'b0, 1'b1, 17'h00010, '0, 4'hF);
            begin
                repeat (3) @(posedge clk);
                do_cmd(0, 1'b1, 1'b0, 17'h00080, 32'h1111_2222, 4'h3);
            end
        join
        wait_drain();
        rd_resp_en = 0;
        check("t4_single_rdv_pulse", pulse_cnt - pc, 1);

        // Read-data strobe while idle is ignored.
        pc = pulse_cnt;
        @(posedge clk); #1 spur_valid = 1'b1;
        @(posedge clk); #1 spur_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("spurious_rdv_ignored", pulse_cnt - pc, 0);
        check("spurious_rdv_not_busy", busy, 0);

        // Requester 2 withdraws before acceptance: no command, pointer unchanged (last=0).
        stall_cfg = 100;
        @(posedge clk); #1;
        req_address[2*AW +: AW] = 17'h00099;
        req_write[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1 req_write[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_not_busy", busy, 0);
        check("drop_no_master_write", avmm_write, 0);
        stall_cfg = 0;
        push_cmd(1'b1, 17'h00111, 32'h0000_0001, 4'hF, 1);
        push_cmd(1'b1, 17'h00333, 32'h0000_0003, 4'hF, 3);
        fork
            do_cmd(1, 1'b1, 1'b0, 17'h00111, 32'h0000_0001, 4'hF);
            do_cmd(3, 1'b1, 1'b0, 17'h00333, 32'h0000_0003, 4'hF);
        join
        wait_drain();

        // T5: reset while waiting for read data, then a fresh grant to requester 3.
        push_cmd(1'b0, 17'h00020, '0, 4'hF, 1);
        do_cmd(1, 1'b0, 1'b1, 17'h00020, '0, 4'hF);
        wait_drain();
        check("t5_busy_in_rdwait", busy, 1);
        @(posedge clk); #1 rst = 1'b1;
        #1 check_reset_values("midrst");
        @(posedge clk); #1 rst = 1'b0;
        push_cmd(1'b1, 17'h00300, 32'h3333_0000, 4'hF, 3);
        do_cmd(3, 1'b1, 1'b0, 17'h00300, 32'h3333_0000, 4'hF);
        wait_drain();
        check("t5_grant_id_fresh", grant_id, 3);

`ifdef AVMM_ARB_TIMEOUT_EN
        // T6: unanswered read times out with the DEAD_BEEF pattern.
        push_cmd(1'b0, 17'h00040, '0, 4'hF, 2);
        push_rd(4'b0100, 32'hDEAD_BEEF);
        do_cmd(2, 1'b0, 1'b1, 17'h00040, '0, 4'hF);
        wait_drain();
        check("t6_timeout_err", timeout_err, 1);
`else
        check("no_watchdog_timeout_err", timeout_err, 0);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
